// File: rtl/ex_stage_if.sv
// Decode-to-execute bundle plus the EX results that flow on to MEM and back
// to decode for forwarding and stalling.
interface ex_stage_if;
  logic [2:0]  alusel_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        flush_i;
  logic [31:0] wdata_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic        stallreq_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output alusel_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    input  wdata_o, wd_o, wreg_o, stallreq_o, hi_o, lo_o
  );

  modport slave (
    input  alusel_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    output wdata_o, wd_o, wreg_o, stallreq_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: logic ops, HI/LO moves, iterative restoring divider
// and optional single-cycle multiplier (enabled by macro EX_MULT_EN).
//
// Divider FSM states:
//   state  | meaning
//   S_IDLE | no divide in flight; a new DIV/DIVU latches operands here
//   S_BUSY | one shift/subtract quotient bit per cycle, stall held high
//   S_DONE | signs applied, HI/LO written on the edge ending this cycle
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_stage_if.slave bus
);

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_MOVE  = 3'b011;

  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_LUI   = 8'b0101_1100;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
`ifdef EX_MULT_EN
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
`endif
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

  div_state_t state, state_nxt;

  logic [2:0]    alusel;
  logic [7:0]    aluop;
  logic [31:0]   reg1, reg2;
  logic          flush;
  logic [31:0]   hi, lo;
  logic [31:0]   quo, rem, divisor;
  logic [CW-1:0] count;
  logic          neg_quo, neg_rem;
  logic          stallreq;
  logic [31:0]   wdata;

  assign alusel = bus.alusel_i;
  assign aluop  = bus.aluop_i;
  assign reg1   = bus.reg1_i;
  assign reg2   = bus.reg2_i;
  assign flush  = bus.flush_i;

  logic is_div, div_signed, div_by_zero, is_mt;
  assign is_div      = (aluop == OP_DIV) || (aluop == OP_DIVU);
  assign div_signed  = (aluop == OP_DIV);
  assign div_by_zero = (reg2 == 32'd0);
  assign is_mt       = (aluop == OP_MTHI) || (aluop == OP_MTLO);

  // Magnitudes fed to the unsigned core; DIVU passes operands through raw.
  logic [31:0] dvd_abs, dvs_abs;
  assign dvd_abs = (div_signed && reg1[31]) ? (32'd0 - reg1) : reg1;
  assign dvs_abs = (div_signed && reg2[31]) ? (32'd0 - reg2) : reg2;

  // Restoring step: a clear borrow bit means the trial subtraction fits.
  logic [32:0] rem_shift, trial;
  assign rem_shift = {rem, quo[31]};
  assign trial     = rem_shift - {1'b0, divisor};

  logic [31:0] quo_final, rem_final;
  assign quo_final = neg_quo ? (32'd0 - quo) : quo;
  assign rem_final = neg_rem ? (32'd0 - rem) : rem;

`ifdef EX_MULT_EN
  logic [63:0] mul_a, mul_b, product;
  assign mul_a   = (aluop == OP_MULT) ? {{32{reg1[31]}}, reg1} : {32'd0, reg1};
  assign mul_b   = (aluop == OP_MULT) ? {{32{reg2[31]}}, reg2} : {32'd0, reg2};
  assign product = mul_a * mul_b;
`endif

  // Divider state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Divider next-state logic; flush aborts from any state.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (is_div) state_nxt = div_by_zero ? S_DONE : S_BUSY;
        S_BUSY:  if (count == LAST_STEP) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Stall request: held from issue until the result is ready in DONE.
  always_comb begin
    stallreq = 1'b0;
    if (!rst && !flush) begin
      case (state)
        S_IDLE:  stallreq = is_div;
        S_BUSY:  stallreq = 1'b1;
        default: stallreq = 1'b0;
      endcase
    end
  end

  // Divider datapath: operand latch at issue, then one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      count   <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (state == S_IDLE && is_div && !flush) begin
      count <= '0;
      if (div_by_zero) begin
        quo     <= 32'hFFFF_FFFF;
        rem     <= reg1;
        neg_quo <= 1'b0;
        neg_rem <= 1'b0;
      end else begin
        quo     <= dvd_abs;
        rem     <= '0;
        divisor <= dvs_abs;
        neg_quo <= div_signed && (reg1[31] ^ reg2[31]);
        neg_rem <= div_signed && reg1[31];
      end
    end else if (state == S_BUSY) begin
      count <= count + CW'(1);
      if (!trial[32]) begin
        rem <= trial[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= rem_shift[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

  // HI/LO writes: divide completion, MTHI/MTLO and (optionally) multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (!flush) begin
      if (state == S_DONE) begin
        hi <= rem_final;
        lo <= quo_final;
      end else if (state == S_IDLE) begin
        case (aluop)
          OP_MTHI: hi <= reg1;
          OP_MTLO: lo <= reg1;
`ifdef EX_MULT_EN
          OP_MULT, OP_MULTU: begin
            hi <= product[63:32];
            lo <= product[31:0];
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // GPR result, combinational from the current decode bundle.
  always_comb begin
    wdata = '0;
    if (!rst) begin
      case (alusel)
        SEL_LOGIC: begin
          case (aluop)
            OP_AND:  wdata = reg1 & reg2;
            OP_OR:   wdata = reg1 | reg2;
            OP_XOR:  wdata = reg1 ^ reg2;
            OP_NOR:  wdata = ~(reg1 | reg2);
            OP_LUI:  wdata = reg1 | reg2;
            default: wdata = '0;
          endcase
        end
        SEL_MOVE: begin
          case (aluop)
            OP_MFHI: wdata = hi;
            OP_MFLO: wdata = lo;
            default: wdata = '0;
          endcase
        end
        default: wdata = '0;
      endcase
    end
  end

  assign bus.wdata_o    = wdata;
  assign bus.wd_o       = rst ? 5'd0 : bus.wd_i;
  assign bus.wreg_o     = !rst && !flush && bus.wreg_i && !is_mt;
  assign bus.stallreq_o = stallreq;
  assign bus.hi_o       = hi;
  assign bus.lo_o       = lo;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage; the HI/LO reference follows EX_MULT_EN.
module tb_ex_stage;

  localparam int DIV_CYCLES = 32;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_LUI   = 8'b0101_1100;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  ex_stage_if bus_if ();

  ex_stage #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wreg);
    bus_if.alusel_i = sel;
    bus_if.aluop_i  = op;
    bus_if.reg1_i   = a;
    bus_if.reg2_i   = b;
    bus_if.wd_i     = wd;
    bus_if.wreg_i   = wreg;
    bus_if.flush_i  = 1'b0;
  endtask

  task automatic nop();
    drive(SEL_NOP, 8'd0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  function automatic logic [31:0] logic_ref(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_LUI:  return a | b;
      default: return 32'd0;
    endcase
  endfunction

  // Quotient truncates toward zero, remainder carries the dividend's sign.
  task automatic div_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint x, y, q, r;
    if (b == 32'd0) begin
      m_lo = 32'hFFFF_FFFF;
      m_hi = a;
    end else begin
      x = sgn ? longint'($signed(a)) : longint'(a);
      y = sgn ? longint'($signed(b)) : longint'(b);
      q = x / y;
      r = x % y;
      m_lo = 32'(q);
      m_hi = 32'(r);
    end
  endtask

  task automatic mult_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic [63:0] p;
    p = sgn ? 64'(longint'($signed(a)) * longint'($signed(b))) : (64'(a) * 64'(b));
`ifdef EX_MULT_EN
    m_hi = p[63:32];
    m_lo = p[31:0];
`else
    if (p == 64'd1) m_hi = m_hi;
`endif
  endtask

  // Called at a sample point where a divide is being presented: counts the
  // stalled cycles, lets DONE retire, then checks HI/LO against the model.
  task automatic wait_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit sgn);
    int n = 0;
    while (bus_if.stallreq_o && n < 200) begin
      n++;
      @(posedge clk); #2;
    end
    chk({tag, "_stall"}, n, (b == 32'd0) ? 32'd1 : 32'(DIV_CYCLES + 1));
    chk({tag, "_done_nostall"}, bus_if.stallreq_o, 1'b0);
    @(posedge clk); #1;
    nop();
    #1;
    div_ref(a, b, sgn);
    chk({tag, "_lo"}, bus_if.lo_o, m_lo);
    chk({tag, "_hi"}, bus_if.hi_o, m_hi);
    chk({tag, "_idle"}, bus_if.stallreq_o, 1'b0);
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input bit sgn);
    drive(SEL_ARITH, sgn ? OP_DIV : OP_DIVU, a, b, 5'd0, 1'b0);
    #1;
    wait_div(tag, a, b, sgn);
  endtask

  initial begin
    logic [31:0] a, b, exp;
    logic [7:0] op;
    logic [7:0] lops [5];
    lops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_LUI};

    // Reset held for two edges with a DIV presented.
    rst = 1'b1;
    drive(SEL_ARITH, OP_DIV, 32'd10, 32'd3, 5'd5, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("rst_hi", bus_if.hi_o, 32'd0);
    chk("rst_lo", bus_if.lo_o, 32'd0);
    chk("rst_stall", bus_if.stallreq_o, 1'b0);
    chk("rst_wreg", bus_if.wreg_o, 1'b0);
    chk("rst_wdata", bus_if.wdata_o, 32'd0);
    chk("rst_wd", bus_if.wd_o, 5'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_release_stall", bus_if.stallreq_o, 1'b1);
    wait_div("rst_div", 32'd10, 32'd3, 1'b1);

    // Directed OR.
    @(posedge clk); #1;
    drive(SEL_LOGIC, OP_OR, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1'b1);
    #1;
    chk("or_wdata", bus_if.wdata_o, 32'h0000_FFFF);
    chk("or_wd", bus_if.wd_o, 5'd5);
    chk("or_wreg", bus_if.wreg_o, 1'b1);
    chk("or_stall", bus_if.stallreq_o, 1'b0);

    // Random logic ops.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      op = lops[$urandom_range(0, 4)];
      a = $urandom();
      b = $urandom();
      drive(SEL_LOGIC, op, a, b, 5'($urandom()), 1'b1);
      #1;
      chk("logic_wdata", bus_if.wdata_o, logic_ref(op, a, b));
      chk("logic_wd", bus_if.wd_o, bus_if.wd_i);
    end

    // Unknown class gives zero result.
    @(posedge clk); #1;
    drive(3'b111, OP_OR, 32'h1234_5678, 32'h0F0F_0F0F, 5'd3, 1'b1);
    #1;
    chk("unknown_wdata", bus_if.wdata_o, 32'd0);

    // MTHI then MFHI, MTLO then MFLO.
    @(posedge clk); #1;
    drive(SEL_MOVE, OP_MTHI, 32'hDEAD_BEEF, 32'd0, 5'd0, 1'b1);
    #1;
    chk("mthi_wreg", bus_if.wreg_o, 1'b0);
    m_hi = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    drive(SEL_MOVE, OP_MFHI, 32'd0, 32'd0, 5'd7, 1'b1);
    #1;
    chk("mfhi_wdata", bus_if.wdata_o, m_hi);
    a = $urandom();
    @(posedge clk); #1;
    drive(SEL_MOVE, OP_MTLO, a, 32'd0, 5'd0, 1'b0);
    m_lo = a;
    @(posedge clk); #1;
    drive(SEL_MOVE, OP_MFLO, 32'd0, 32'd0, 5'd8, 1'b1);
    #1;
    chk("mflo_wdata", bus_if.wdata_o, m_lo);
    chk("mtlo_hi_kept", bus_if.hi_o, m_hi);

    // Directed divides and divide-by-zero.
    @(posedge clk); #1;
    run_div("div_neg7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    chk("div_neg7_2_lo_const", bus_if.lo_o, 32'hFFFF_FFFD);
    chk("div_neg7_2_hi_const", bus_if.hi_o, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    run_div("divu_100_7", 32'd100, 32'd7, 1'b0);
    @(posedge clk); #1;
    run_div("divu_by0", 32'd9, 32'd0, 1'b0);
    @(posedge clk); #1;
    run_div("div_by0_neg", 32'hFFFF_FF00, 32'd0, 1'b1);

    // Flush at the tenth BUSY cycle.
    @(posedge clk); #1;
    drive(SEL_ARITH, OP_DIV, 32'd1000, 32'd3, 5'd4, 1'b1);
    #1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
    end
    chk("flush_busy_stall", bus_if.stallreq_o, 1'b1);
    bus_if.flush_i = 1'b1;
    #1;
    chk("flush_stall", bus_if.stallreq_o, 1'b0);
    chk("flush_wreg", bus_if.wreg_o, 1'b0);
    @(posedge clk); #1;
    nop();
    #1;
    chk("flush_hi", bus_if.hi_o, m_hi);
    chk("flush_lo", bus_if.lo_o, m_lo);
    chk("flush_idle", bus_if.stallreq_o, 1'b0);

    // Flush while a DIV sits in IDLE: no stall, no issue.
    @(posedge clk); #1;
    drive(SEL_ARITH, OP_DIVU, 32'd50, 32'd5, 5'd0, 1'b0);
    bus_if.flush_i = 1'b1;
    #1;
    chk("flush_idle_stall", bus_if.stallreq_o, 1'b0);
    @(posedge clk); #1;
    nop();
    #1;
    chk("flush_idle_lo", bus_if.lo_o, m_lo);

    // Random divides, occasional zero divisor.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      a = $urandom();
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom() >> $urandom_range(0, 28);
      run_div("div_rand", a, b, 1'($urandom_range(0, 1)));
    end

    // Multiply (or NOP when the feature is absent).
    @(posedge clk); #1;
    drive(SEL_ARITH, OP_MULT, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b0);
    #1;
    chk("mult_stall", bus_if.stallreq_o, 1'b0);
    chk("mult_wdata", bus_if.wdata_o, 32'd0);
    mult_ref(32'hFFFF_FFFF, 32'd2, 1'b1);
    @(posedge clk); #1;
    nop();
    #1;
    chk("mult_hi", bus_if.hi_o, m_hi);
    chk("mult_lo", bus_if.lo_o, m_lo);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      a = $urandom();
      b = $urandom();
      op = (i % 2 == 0) ? OP_MULT : OP_MULTU;
      drive(SEL_ARITH, op, a, b, 5'd0, 1'b0);
      #1;
      chk("mult_rand_stall", bus_if.stallreq_o, 1'b0);
      mult_ref(a, b, op == OP_MULT);
      @(posedge clk); #1;
      nop();
      #1;
      chk("mult_rand_hi", bus_if.hi_o, m_hi);
      chk("mult_rand_lo", bus_if.lo_o, m_lo);
    end

    // Reset during BUSY clears everything.
    @(posedge clk); #1;
    drive(SEL_ARITH, OP_DIVU, 32'd77, 32'd3, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    nop();
    rst = 1'b0;
    #1;
    chk("rst_busy_hi", bus_if.hi_o, 32'd0);
    chk("rst_busy_lo", bus_if.lo_o, 32'd0);
    chk("rst_busy_stall", bus_if.stallreq_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage via the ID/EX pipeline register.
- Consumes the decode bundle: alusel, aluop, operand 1/2, destination, write enable.
- Produces the EX/MEM bundle plus the ex_* forwarding signals that feed back into decode.
- Owns the HI/LO register pair and an iterative 32-cycle divider, and requests a pipeline stall while a divide is in flight.

Parameters:
- DIV_CYCLES, 32, number of BUSY iterations of the restoring divider; one quotient bit per cycle; must equal the data width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- alusel_i  in  3  instruction class from decode (Logic, Move, Arith), shared defines.v codes
- aluop_i  in  8  operation from decode, shared defines.v codes; adds DIV, DIVU, MULT, MULTU
- reg1_i  in  32  operand 1, already forwarded or immediate
- reg2_i  in  32  operand 2, already forwarded or immediate
- wd_i  in  5  destination GPR
- wreg_i  in  1  GPR write enable
- flush_i  in  1  kill the current EX instruction and abort any divide
- wdata_o  out  32  GPR result; combinational from the current inputs
- wd_o  out  5  equals wd_i
- wreg_o  out  1  equals wreg_i, gated by flush_i
- stallreq_o  out  1  freeze PC, IF/ID and ID/EX registers this cycle
- hi_o  out  32  current HI register
- lo_o  out  32  current LO register

Behaviour:
- Reset (rst=1 at a posedge): HI=0, LO=0, divider state=IDLE, internal quotient/remainder/counter=0. While rst=1: stallreq_o=0, wreg_o=0, wdata_o=0, wd_o=0.
- Logic: AND/ANDI, OR/ORI, XOR/XORI, NOR, and LUI as reg1|reg2. Combinational, zero latency.
- MFHI/MFLO: wdata_o = HI/LO.
- MTHI/MTLO: HI/LO <= reg1_i at the clock edge ending the cycle; wreg_o=0.
- HI/LO read-after-write is clean because HI/LO update in EX. The register value is correct for the very next instruction; no bypass needed.
- Divider FSM:
  - IDLE: if aluop is DIV/DIVU and flush_i=0, stallreq_o=1.
    - reg2_i==0: go to DONE next cycle with quotient=32'hFFFFFFFF and remainder=reg1_i.
    - otherwise: latch |dividend| and |divisor| (DIVU: raw values), record the sign flags, clear the counter, go to BUSY.
  - BUSY: stallreq_o=1. One shift/subtract step per cycle; counter increments. After DIV_CYCLES steps go to DONE.
  - DONE: stallreq_o=0. Apply signs: quotient is negated if the operand signs differ; remainder takes the dividend's sign. At the edge ending DONE, LO<=quotient, HI<=remainder, state->IDLE. The pipeline advances on that same edge, so the divide is not re-issued.
- Divide latency: 34 EX cycles (1 IDLE + 32 BUSY + 1 DONE), stallreq_o high for the first 33.
- Divide by zero: 2 EX cycles (IDLE, DONE).
- flush_i=1 in any state: state->IDLE next edge, HI/LO untouched, stallreq_o=0 that cycle, wreg_o=0.
- rst during BUSY: full reset applies; no HI/LO write.
- Operand stability: upstream holds alusel/aluop/reg1/reg2 stable while stallreq_o=1. The divider uses only latched copies after IDLE.
- Unknown alusel/aluop: wdata_o=0, no HI/LO write.

Optional Feature:
- Macro EX_MULT_EN.
- Defined: MULT/MULTU compute the 64-bit product in one cycle, HI<=product[63:32], LO<=product[31:0]. MULT is signed, MULTU unsigned. No stall.
- Undefined: MULT/MULTU behave as NOP: no HI/LO write, wdata_o=0, no stall.

Test Plan:
- Reset: rst=1 for 2 cycles with DIV presented -> hi_o=lo_o=0, stallreq_o=0; first cycle after rst=0 -> stallreq_o=1.
- Logic: OR reg1=32'h0000F0F0, reg2=32'h00000F0F, wd=5, wreg=1 -> same cycle wdata_o=32'h0000FFFF, wd_o=5, wreg_o=1.
- HI/LO move: MTHI reg1=32'hDEADBEEF, then MFHI next cycle -> wdata_o=32'hDEADBEEF.
- Divide: DIV reg1=-7 (32'hFFFFFFF9), reg2=2 -> stallreq_o high exactly 33 cycles; afterwards lo_o=32'hFFFFFFFD, hi_o=32'hFFFFFFFF. DIVU of 100 by 7 -> lo=14, hi=2.
- Divide boundaries: DIVU reg2=0 with reg1=9 -> stall 1 cycle, lo=32'hFFFFFFFF, hi=9. flush_i at BUSY cycle 10 -> stall drops that cycle, HI/LO unchanged.
- Multiply: with EX_MULT_EN, MULT 32'hFFFFFFFF x 2 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFE, no stall. Without the macro -> HI/LO unchanged.
